// File: rtl/bsram_sd_sequencer_pkg.sv
// snes_bk_pkg: types and constants shared by the BSRAM <-> SD sector sequencer.
//   bk_state_t   : sequencer FSM states
//   bk_dir_t     : transfer direction (load = SD -> BSRAM, save = BSRAM -> SD)
//   SECTOR_SHIFT : log2 of the SD sector size in bytes
package snes_bk_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } bk_state_t;

  typedef enum logic {
    BK_LOAD = 1'b0,
    BK_SAVE = 1'b1
  } bk_dir_t;

  localparam int unsigned SECTOR_SHIFT = 9;

endpackage

// File: rtl/bsram_sd_sequencer_ack_timer.sv
// bk_ack_timer: resettable free-running counter used as the sd_ack watchdog.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   clr_i  : synchronous clear (dominates en_i)
//   en_i   : count enable
//   tc_o   : terminal count (counter is all-ones)
module bk_ack_timer #(
  parameter int unsigned TO_W = 24
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [TO_W-1:0] cnt_q;
  logic [TO_W-1:0] cnt_d;

  // Next count: clear on state entry, otherwise advance while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {TO_W{1'b0}};
    end else if (en_i) begin
      cnt_d = cnt_q + {{(TO_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= {TO_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == {TO_W{1'b1}});

endmodule

// File: rtl/bsram_sd_sequencer.sv
// bsram_sd_sequencer: walks BSRAM sectors 0..ram_mask[23:9] over the HPS
// sd_rd/sd_wr/sd_ack handshake, auto-loading after each ROM download and
// serving OSD load/save requests.
//   clk_sys, reset_n            : clock, async active-low reset
//   ioctl_download              : ROM download in progress
//   img_mounted/readonly/size   : SD image mount information
//   ram_mask                    : BSRAM byte mask (size-1)
//   load_req, save_req          : OSD request levels (rising edge acts)
//   bsram_wr                    : console write strobe (dirty tracking)
//   sd_ack                      : HPS sector acknowledge
//   sd_lba, sd_rd, sd_wr        : sector request
//   bk_ena/loading/busy/dirty/error : status
module bsram_sd_sequencer
  import snes_bk_pkg::*;
#(
  parameter int unsigned TO_W  = 24,
  parameter int unsigned LBA_W = 15
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        img_mounted,
  input  logic        img_readonly,
  input  logic [63:0] img_size,
  input  logic [23:0] ram_mask,
  input  logic        load_req,
  input  logic        save_req,
  input  logic        bsram_wr,
  input  logic        sd_ack,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  output logic        bk_ena,
  output logic        bk_loading,
  output logic        bk_busy,
  output logic        bk_dirty,
  output logic        bk_error
);

  bk_state_t   state_q, state_d;
  bk_dir_t     dir_q, dir_d;
  logic [31:0] lba_q, lba_d;
  logic        rd_q, rd_d, wr_q, wr_d, ena_q, ena_d;
  logic        loading_q, loading_d, busy_q, busy_d;
  logic        dirty_q, dirty_d, error_q, error_d;
  logic        ld_q, ld_qq, sv_q, sv_qq, dl_q, ack_q;

  logic        ld_edge_s, sv_edge_s, dl_rise_s, dl_fall_s;
  logic        ack_rise_s, ack_fall_s;
  logic        timer_clr_s, timer_en_s, timer_tc_s;
  logic        start_s, start_load_s, abort_s;
  logic [LBA_W-1:0] last_lba_s;
  logic        unused_mask_s;

  // Request edges are taken one stage late so the start lands 2 cycles after the level rises.
  assign ld_edge_s  = ld_q & ~ld_qq & ena_q;
  assign sv_edge_s  = sv_q & ~sv_qq & ena_q;
  assign dl_rise_s  = ioctl_download & ~dl_q;
  assign dl_fall_s  = ~ioctl_download & dl_q;
  assign ack_rise_s = sd_ack & ~ack_q;
  assign ack_fall_s = ~sd_ack & ack_q;

  assign last_lba_s    = ram_mask[SECTOR_SHIFT +: LBA_W];
  assign unused_mask_s = ^ram_mask[SECTOR_SHIFT-1:0];
  assign timer_en_s    = (state_q == ISSUE) || (state_q == WAIT_DONE);

  bk_ack_timer #(.TO_W(TO_W)) u_timer (
    .clk_i  (clk_sys),
    .rst_ni (reset_n),
    .clr_i  (timer_clr_s),
    .en_i   (timer_en_s),
    .tc_o   (timer_tc_s)
  );

  // Next-state and output logic of the transfer sequencer.
  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    lba_d        = lba_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    ena_d        = ena_q;
    loading_d    = loading_q;
    busy_d       = busy_q;
    dirty_d      = dirty_q;
    error_d      = error_q;
    timer_clr_s  = 1'b0;
    start_s      = 1'b0;
    start_load_s = 1'b0;
    abort_s      = 1'b0;

    // Writes during a transfer are the SD data itself, not user changes.
    if (bsram_wr && !busy_q) begin
      dirty_d = 1'b1;
    end else begin
      dirty_d = dirty_q;
    end

    case (state_q)
      IDLE: begin
        if ((dl_fall_s && ena_q) || ld_edge_s) begin
          start_s      = 1'b1;
          start_load_s = 1'b1;
        end else if (sv_edge_s) begin
          start_s      = 1'b1;
          start_load_s = 1'b0;
        end else begin
          start_s      = 1'b0;
        end
        if (start_s) begin
          state_d     = ISSUE;
          dir_d       = start_load_s ? BK_LOAD : BK_SAVE;
          lba_d       = 32'd0;
          loading_d   = start_load_s;
          busy_d      = 1'b1;
          error_d     = 1'b0;
          rd_d        = start_load_s;
          wr_d        = ~start_load_s;
          timer_clr_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (ack_rise_s) begin
          rd_d        = 1'b0;
          wr_d        = 1'b0;
          state_d     = WAIT_DONE;
          timer_clr_s = 1'b1;
        end else if (timer_tc_s) begin
          abort_s = 1'b1;
        end else begin
          state_d = ISSUE;
        end
      end
      WAIT_DONE: begin
        if (ack_fall_s) begin
          if (lba_q[LBA_W-1:0] >= last_lba_s) begin
            loading_d = 1'b0;
            busy_d    = 1'b0;
            dirty_d   = 1'b0;
            state_d   = IDLE;
          end else begin
            lba_d       = lba_q + 32'd1;
            rd_d        = (dir_q == BK_LOAD);
            wr_d        = (dir_q == BK_SAVE);
            state_d     = ISSUE;
            timer_clr_s = 1'b1;
          end
        end else if (timer_tc_s) begin
          abort_s = 1'b1;
        end else begin
          state_d = WAIT_DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (abort_s) begin
      error_d   = 1'b1;
      rd_d      = 1'b0;
      wr_d      = 1'b0;
      loading_d = 1'b0;
      busy_d    = 1'b0;
      state_d   = IDLE;
    end else begin
      error_d = error_d;
    end

    // A new ROM download invalidates the BSRAM image and kills any transfer.
    if (dl_rise_s) begin
      state_d   = IDLE;
      rd_d      = 1'b0;
      wr_d      = 1'b0;
      loading_d = 1'b0;
      busy_d    = 1'b0;
      ena_d     = 1'b0;
      dirty_d   = 1'b0;
    end else begin
      ena_d = ena_d;
    end

    // Mount of a usable image during download: set wins over the clear above.
    if (ioctl_download && img_mounted && (img_size != 64'd0) && !img_readonly) begin
      ena_d = 1'b1;
    end else begin
      ena_d = ena_d;
    end
  end

  // State, status and edge-detect registers.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      dir_q     <= BK_LOAD;
      lba_q     <= 32'd0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      ena_q     <= 1'b0;
      loading_q <= 1'b0;
      busy_q    <= 1'b0;
      dirty_q   <= 1'b0;
      error_q   <= 1'b0;
      ld_q      <= 1'b0;
      ld_qq     <= 1'b0;
      sv_q      <= 1'b0;
      sv_qq     <= 1'b0;
      dl_q      <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      lba_q     <= lba_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      ena_q     <= ena_d;
      loading_q <= loading_d;
      busy_q    <= busy_d;
      dirty_q   <= dirty_d;
      error_q   <= error_d;
      ld_q      <= load_req;
      ld_qq     <= ld_q;
      sv_q      <= save_req;
      sv_qq     <= sv_q;
      dl_q      <= ioctl_download;
      ack_q     <= sd_ack;
    end
  end

  assign sd_lba     = lba_q;
  assign sd_rd      = rd_q;
  assign sd_wr      = wr_q;
  assign bk_ena     = ena_q;
  assign bk_loading = loading_q;
  assign bk_busy    = busy_q;
  assign bk_dirty   = dirty_q;
  assign bk_error   = error_q;

endmodule

// File: tb/tb_bsram_sd_sequencer.sv
// Self-checking bench for bsram_sd_sequencer: every sector request the DUT
// raises is matched against an expected (direction, sector) list built from
// the mask when the request is issued.
module tb_bsram_sd_sequencer;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_download = 1'b0;
  logic        img_mounted = 1'b0;
  logic        img_readonly = 1'b0;
  logic [63:0] img_size = 64'd0;
  logic [23:0] ram_mask = 24'd0;
  logic        load_req = 1'b0;
  logic        save_req = 1'b0;
  logic        bsram_wr = 1'b0;
  logic        sd_ack = 1'b0;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr, bk_ena, bk_loading, bk_busy, bk_dirty, bk_error;

  typedef struct packed {
    logic        ld;
    logic [31:0] lba;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  bsram_sd_sequencer #(.TO_W(8), .LBA_W(15)) dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .img_mounted    (img_mounted),
    .img_readonly   (img_readonly),
    .img_size       (img_size),
    .ram_mask       (ram_mask),
    .load_req       (load_req),
    .save_req       (save_req),
    .bsram_wr       (bsram_wr),
    .sd_ack         (sd_ack),
    .sd_lba         (sd_lba),
    .sd_rd          (sd_rd),
    .sd_wr          (sd_wr),
    .bk_ena         (bk_ena),
    .bk_loading     (bk_loading),
    .bk_busy        (bk_busy),
    .bk_dirty       (bk_dirty),
    .bk_error       (bk_error)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Number of sectors a mask covers: whole 512-byte sectors, at least one.
  function automatic int nsec_of(input logic [23:0] mask);
    return int'(mask / 24'd512) + 1;
  endfunction

  task automatic push_xfer(input bit ld, input logic [23:0] mask);
    for (int i = 0; i < nsec_of(mask); i++) begin
      exp_q.push_back('{ld: ld, lba: i});
    end
  endtask

  // Issue a request through the OSD level and record the expected sectors.
  task automatic issue(input bit ld, input logic [23:0] mask);
    ram_mask = mask;
    push_xfer(ld, mask);
    if (ld) load_req = 1'b1;
    else    save_req = 1'b1;
    repeat (3) tick();
    load_req = 1'b0;
    save_req = 1'b0;
  endtask

  // HPS side of one sector: wait for the request, ack it, release the ack.
  task automatic do_sector();
    int n;
    n = 0;
    while (!(sd_rd || sd_wr) && n < 100) begin tick(); n++; end
    chk("req_wait", {31'd0, sd_rd | sd_wr}, 32'd1);
    repeat ($urandom_range(0, 3)) tick();
    sd_ack = 1'b1;
    n = 0;
    while ((sd_rd || sd_wr) && n < 10) begin tick(); n++; end
    chk("req_drop", {31'd0, sd_rd | sd_wr}, 32'd0);
    repeat ($urandom_range(0, 3)) tick();
    sd_ack = 1'b0;
    tick();
  endtask

  task automatic finish_xfer(input int nsec);
    for (int i = 0; i < nsec; i++) do_sector();
    tick();
    chk("end_busy", {31'd0, bk_busy}, 32'd0);
    chk("end_loading", {31'd0, bk_loading}, 32'd0);
    chk("end_dirty", {31'd0, bk_dirty}, 32'd0);
  endtask

  task automatic mount_writable();
    ioctl_download = 1'b1;
    tick();
    img_mounted = 1'b1; img_size = 64'd8192; img_readonly = 1'b0;
    tick();
    img_mounted = 1'b0;
    tick();
    chk("mount_ena", {31'd0, bk_ena}, 32'd1);
  endtask

  // Scoreboard monitor: each newly raised request must match the next expectation.
  initial begin
    logic prev, cur;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk_sys);
      cur = sd_rd | sd_wr;
      if (cur && !prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req actual rd=%0b wr=%0b lba=%0d required=no request", sd_rd, sd_wr, sd_lba);
        end else begin
          e = exp_q.pop_front();
          chk("req_rd", {31'd0, sd_rd}, {31'd0, e.ld});
          chk("req_wr", {31'd0, sd_wr}, {31'd0, ~e.ld});
          chk("req_lba", sd_lba, e.lba);
          chk("req_loading", {31'd0, bk_loading}, {31'd0, e.ld});
          chk("req_busy", {31'd0, bk_busy}, 32'd1);
        end
      end
      prev = cur;
    end
  end

  initial begin
    int n;
    bit ld;
    logic [23:0] mask;

    // Reset state
    repeat (3) tick();
    chk("rst_lba", sd_lba, 32'd0);
    chk("rst_rdwr", {30'd0, sd_rd, sd_wr}, 32'd0);
    chk("rst_flags", {27'd0, bk_ena, bk_loading, bk_busy, bk_dirty, bk_error}, 32'd0);
    reset_n = 1'b1;
    tick();

    // 1: auto-load of 16 sectors after download; console writes during load ignored
    ram_mask = 24'h1FFF;
    mount_writable();
    push_xfer(1'b1, 24'h1FFF);
    ioctl_download = 1'b0;
    do_sector();
    bsram_wr = 1'b1; tick(); bsram_wr = 1'b0; tick();
    chk("load_dirty_mid", {31'd0, bk_dirty}, 32'd0);
    finish_xfer(15);
    chk("load_error", {31'd0, bk_error}, 32'd0);

    // 2: dirty save of 4 sectors, 2-cycle request latency
    bsram_wr = 1'b1; tick(); bsram_wr = 1'b0; tick();
    chk("dirty_set", {31'd0, bk_dirty}, 32'd1);
    ram_mask = 24'h07FF;
    push_xfer(1'b0, 24'h07FF);
    save_req = 1'b1;
    tick();
    chk("lat_1cyc", {31'd0, sd_wr}, 32'd0);
    tick();
    chk("lat_2cyc", {31'd0, sd_wr}, 32'd1);
    save_req = 1'b0;
    do_sector();
    chk("save_dirty_mid", {31'd0, bk_dirty}, 32'd1);
    finish_xfer(3);

    // 4: simultaneous load and save edges -> load only; save edge mid-transfer ignored
    ram_mask = 24'h03FF;
    push_xfer(1'b1, 24'h03FF);
    load_req = 1'b1; save_req = 1'b1;
    repeat (3) tick();
    save_req = 1'b0;
    repeat (2) tick();
    save_req = 1'b1;
    finish_xfer(2);
    load_req = 1'b0; save_req = 1'b0;
    repeat (10) tick();

    // 5: no ack -> timeout abort; next request clears the error
    ram_mask = 24'h01FF;
    push_xfer(1'b1, 24'h01FF);
    load_req = 1'b1;
    n = 0;
    while (!sd_rd && n < 20) begin tick(); n++; end
    load_req = 1'b0;
    n = 0;
    while (sd_rd && n < 400) begin tick(); n++; end
    checks++;
    if (n < 250 || n > 260) begin
      errors++;
      $display("FAIL timeout_len actual=%0d cycles required=250..260", n);
    end
    chk("to_error", {31'd0, bk_error}, 32'd1);
    chk("to_busy", {31'd0, bk_busy}, 32'd0);
    chk("to_loading", {31'd0, bk_loading}, 32'd0);
    issue(1'b1, 24'h01FF);
    chk("to_error_clr", {31'd0, bk_error}, 32'd0);
    finish_xfer(1);

    // Randomized transfers, first one with a sub-sector mask
    for (int k = 0; k < 3; k++) begin
      ld = 1'($urandom_range(0, 1));
      mask = (k == 0) ? 24'h0000FF : 24'($urandom_range(0, 32'h1FFF));
      issue(ld, mask);
      finish_xfer(nsec_of(mask));
    end

    // 6: download rises during sector 3 of an 8-sector save
    issue(1'b0, 24'h0FFF);
    for (int i = 0; i < 3; i++) do_sector();
    n = 0;
    while (!sd_wr && n < 100) begin tick(); n++; end
    sd_ack = 1'b1;
    tick(); tick();
    ioctl_download = 1'b1;
    tick();
    chk("dl_wr", {31'd0, sd_wr}, 32'd0);
    chk("dl_busy", {31'd0, bk_busy}, 32'd0);
    chk("dl_ena", {31'd0, bk_ena}, 32'd0);
    exp_q.delete();
    sd_ack = 1'b0;
    repeat (3) tick();
    chk("dl_lba_hold", sd_lba, 32'd3);
    chk("dl_no_req", {30'd0, sd_rd, sd_wr}, 32'd0);
    ioctl_download = 1'b0;
    repeat (5) tick();
    chk("dl_no_autoload", {31'd0, bk_busy}, 32'd0);

    // 3: read-only image -> no enable, requests ignored
    ioctl_download = 1'b1;
    tick();
    img_mounted = 1'b1; img_readonly = 1'b1;
    tick();
    img_mounted = 1'b0;
    tick();
    ioctl_download = 1'b0;
    repeat (3) tick();
    chk("ro_ena", {31'd0, bk_ena}, 32'd0);
    load_req = 1'b1; tick(); tick(); load_req = 1'b0; tick();
    save_req = 1'b1; tick(); tick(); save_req = 1'b0;
    repeat (8) tick();
    chk("ro_no_req", {29'd0, sd_rd, sd_wr, bk_busy}, 32'd0);

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bsram_sd_sequencer.md
Name: bsram_sd_sequencer

Overview:
Sequences cartridge backup RAM (BSRAM) transfers between the on-chip BSRAM port and the HPS SD-image sector interface.
It decides when a save image is usable and accepts OSD load/save requests. After every ROM download it auto-loads the save file. It walks sectors 0..N, using the sd_rd/sd_wr/sd_ack handshake, with a timeout.
Its outputs `bk_loading` and `bk_busy` let the system hold the console in reset while the BSRAM contents are being replaced.

Parameters:
- TO_W, 24: width of the ack-timeout counter; timeout = 2^TO_W-1 clk_sys cycles.
- LBA_W, 15: number of significant sector-index bits (`ram_mask[23:9]`).

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- ioctl_download  in  1  ROM download in progress
- img_mounted  in  1  one-cycle pulse: SD image mounted
- img_readonly  in  1  mounted image is read-only
- img_size  in  64  mounted image size in bytes
- ram_mask  in  24  BSRAM byte mask (size-1)
- load_req  in  1  OSD load level; acted on at its rising edge
- save_req  in  1  OSD save level; acted on at its rising edge
- bsram_wr  in  1  console write strobe to BSRAM (dirty tracking)
- sd_ack  in  1  HPS sector-transfer acknowledge
- sd_lba  out  32  current sector index
- sd_rd  out  1  sector read request
- sd_wr  out  1  sector write request
- bk_ena  out  1  save image valid
- bk_loading  out  1  load transfer active
- bk_busy  out  1  any transfer active
- bk_dirty  out  1  BSRAM written since last load/save
- bk_error  out  1  last transfer aborted on timeout

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; edge-detect registers 0.
- Enable (`bk_ena`):
  - Cleared on the rising edge of `ioctl_download`.
  - Set in any cycle where `ioctl_download & img_mounted & (img_size!=0) & ~img_readonly`.
  - Both in the same cycle: the set wins.
- Edge detection:
  - `load_req` and `save_req` are registered and gated by `bk_ena`.
  - The download falling edge is taken from the registered `ioctl_download`.
- FSM states: IDLE, ISSUE, WAIT_DONE.
- IDLE:
  - Start sources, in priority order: (1) download falling edge with `bk_ena`; (2) load edge; (3) save edge.
  - Source (1) or (2) starts a load; source (3) starts a save. Simultaneous load and save edges: the load wins and the save is dropped.
  - On start: `sd_lba`<=0, `bk_loading`<=(load), `bk_busy`<=1, `bk_error`<=0, `sd_rd`<=load, `sd_wr`<=~load. Next state is ISSUE.
  - Request edges arriving in any other state are ignored, not queued.
- ISSUE:
  - On the `sd_ack` rising edge: clear `sd_rd`/`sd_wr` in the same cycle; next state is WAIT_DONE.
  - If the timeout counter reaches all-ones first: abort.
- WAIT_DONE:
  - On the `sd_ack` falling edge:
    - If `sd_lba[LBA_W-1:0] >= ram_mask[23:9]`: transfer complete. Clear `bk_loading`/`bk_busy`, clear `bk_dirty`, go to IDLE.
    - Otherwise: `sd_lba`<=`sd_lba`+1, re-assert `sd_rd`/`sd_wr` per direction, go to ISSUE.
  - The timeout applies here too.
- Timeout counter:
  - Reset to 0 on every ISSUE or WAIT_DONE entry; increments each cycle in those states.
  - Abort: set `bk_error`; clear `sd_rd`, `sd_wr`, `bk_loading`, `bk_busy`; go to IDLE. `bk_dirty` is unchanged.
- Sector count: `ram_mask[23:9]`+1 sectors (sectors 0..`ram_mask[23:9]` inclusive). When `ram_mask`<512 the sequencer still transfers exactly one sector.
- Dirty flag: `bk_dirty` is set by `bsram_wr` only while `~bk_busy`. BSRAM writes during a load are the SD data itself and do not set it.
- Download start mid-transfer: the `ioctl_download` rising edge forces IDLE in the same cycle. It clears `sd_rd`, `sd_wr`, `bk_loading`, `bk_busy`, `bk_ena` and `bk_dirty`; `bk_error` is unchanged.
- Async reset mid-transfer returns every output to its reset value immediately.
- Latency: `sd_rd`/`sd_wr` assert 2 cycles after the request level rises (1 cycle for edge registration, 1 cycle for the IDLE transition).
- `sd_lba` is stable from request assertion through the `sd_ack` falling edge.

Decomposition:
- Shared package `snes_bk_pkg`:
  - State enum `bk_state_t` {IDLE, ISSUE, WAIT_DONE}.
  - Constant `SECTOR_SHIFT`=9.
  - Direction typedef `bk_dir_t` {BK_LOAD, BK_SAVE}.
- Sub-module `bk_ack_timer`: the resettable TO_W timeout counter with a terminal-count flag. Everything else stays in the top module.

Test Plan:
1. Mount a writable image (`img_size`=8192) during download, then drop `ioctl_download` with `ram_mask`=0x1FFF → 16 reads, `sd_lba` 0..15, `bk_loading` high throughout, then all outputs idle and `bk_dirty`=0.
2. `bk_ena`=1, pulse `bsram_wr`, raise `save_req` with `ram_mask`=0x07FF → `bk_dirty`=1; 4 writes `sd_lba` 0..3 with `bk_loading`=0; `bk_dirty`=0 after the 4th `sd_ack` falls.
3. `img_readonly`=1 at mount → `bk_ena`=0; `load_req`/`save_req` edges produce no `sd_rd`/`sd_wr`.
4. `load_req` and `save_req` rise in the same cycle → load only; a second `save_req` edge during the transfer is ignored.
5. `sd_ack` never rises (TO_W=8 in the bench) → `sd_rd` drops after 255 cycles, `bk_error`=1, `bk_busy`=0; the next request clears `bk_error`.
6. `ioctl_download` rises during sector 3 of a save → next cycle: `sd_wr`=0, `bk_busy`=0, `bk_ena`=0; a later `sd_ack` falling edge causes no `sd_lba` change.
